// File: rtl/tiled_layer_pkg.sv
// Shared types for the tiled strip layer: command word layout,
// per-channel strip state and the built-in ground tile images.
package tiled_layer_pkg;

    localparam logic [3:0] ACT_SWAP  = 4'hF;
    localparam logic [3:0] ACT_WRITE = 4'h1;

    localparam logic [2:0] TYPE_CTRL  = 3'b001;
    localparam logic [2:0] TYPE_X     = 3'b010;
    localparam logic [2:0] TYPE_Y     = 3'b011;
    localparam logic [2:0] TYPE_SPAN  = 3'b100;
    localparam logic [2:0] TYPE_GAPL  = 3'b101;
    localparam logic [2:0] TYPE_GAPR  = 3'b110;
    localparam logic [2:0] TYPE_SPEED = 3'b111;

    typedef struct packed {
        logic [5:0]  component;
        logic [4:0]  channel;
        logic [3:0]  action;
        logic [2:0]  ctype;
        logic        bank;
        logic [12:0] message;
    } cmd_t;

    typedef struct packed {
        logic       visible;
        logic       flip;
        logic [4:0] pattern;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] span;
        logic [9:0] gap_l;
        logic [9:0] gap_r;
        logic [5:0] speed;
    } ch_state_t;

    function automatic cmd_t decode_cmd(input logic [31:0] word);
        return cmd_t'(word);
    endfunction

    // Bank write aimed at this component (channel range checked by caller).
    function automatic logic cmd_is_write(input cmd_t c, input logic [5:0] id);
        return (c.action == ACT_WRITE) && (c.component == id);
    endfunction

    function automatic logic [9:0] speed_ext(input logic [5:0] s);
        return {{4{s[5]}}, s};
    endfunction

    // Ground tile image: colour index before truncation to BPP bits.
    function automatic int ground_pixel(input int pattern, input int row,
                                        input int col);
        return col + (col >> 2) + (row >> 2) + 2 * pattern;
    endfunction

    function automatic logic [23:0] ground_color(input int idx);
        return 24'(idx) * 24'h405060 + 24'h0A0B0C;
    endfunction

endpackage

// File: rtl/tiled_layer_display_addr.sv
// Per-channel strip hit test and tile pixel address generator.
// Purely combinational; the caller registers the results.
module strip_addr_gen
    import tiled_layer_pkg::*;
#(
    parameter int TILE_W = 16,
    parameter int TILE_H = 16,
    parameter int ADDR_W = 9
) (
    input  ch_state_t         i_state,
    input  logic [9:0]        i_hcount,
    input  logic [9:0]        i_vcount,
    input  logic [9:0]        i_scroll,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr
);
    localparam int CW = $clog2(TILE_W);
    localparam int RW = $clog2(TILE_H);
    localparam logic [ADDR_W-1:0] PAT_SIZE = ADDR_W'(TILE_W * TILE_H);

    logic [10:0]   w_x_end;
    logic [10:0]   w_y_end;
    logic          w_in_x;
    logic          w_in_y;
    logic          w_in_gap;
    logic [CW-1:0] w_col_raw;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_unused_speed;

    // Extents are compared at 11 bits so X+span never wraps.
    assign w_x_end = {1'b0, i_state.x} + {1'b0, i_state.span};
    assign w_y_end = {1'b0, i_state.y} + 11'(TILE_H);

    assign w_in_x = (i_hcount >= i_state.x) &&
                    ({1'b0, i_hcount} < w_x_end);
    assign w_in_y = (i_vcount >= i_state.y) &&
                    ({1'b0, i_vcount} < w_y_end);

    // An inverted window (gap_l > gap_r) disables the hole.
    assign w_in_gap = (i_state.gap_l <= i_state.gap_r) &&
                      (i_hcount >= i_state.gap_l) &&
                      (i_hcount <= i_state.gap_r);

    assign o_hit = i_state.visible && w_in_x && w_in_y && !w_in_gap;

    // TILE_W is a power of two, so mod is a truncation and the
    // mirror TILE_W-1-col is a bitwise invert.
    assign w_col_raw = CW'(i_hcount - i_state.x + i_scroll);
    assign w_col     = i_state.flip ? ~w_col_raw : w_col_raw;
    assign w_row     = RW'(i_vcount - i_state.y);

    assign o_addr = ADDR_W'(i_state.pattern) * PAT_SIZE
                  + ADDR_W'(w_row) * ADDR_W'(TILE_W)
                  + ADDR_W'(w_col);

    // Speed only drives the scroll accumulators in the top level.
    assign w_unused_speed = ^i_state.speed;

endmodule

// File: rtl/tiled_layer_display.sv
// Multi-channel tiled strip layer: ping-pong command banks, per-frame
// scroll, two-stage pixel pipeline and lowest-channel-wins compositing.
module tiled_layer_display
    import tiled_layer_pkg::*;
#(
    parameter logic [5:0]  COMPONENT_ID = 6'b001111,
    parameter int          NUM_CHANNELS = 4,
    parameter int          BPP          = 2,
    parameter int          TILE_W       = 16,
    parameter int          TILE_H       = 16,
    parameter int          NUM_PATTERNS = 2,
    parameter logic [23:0] BG_COLOR     = 24'h202020,
    parameter              MEM_FILE     = "Ground_tiles.txt",
    parameter              PALETTE_FILE = "Ground_palette.txt"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [23:0] RGB_output,
    output logic        opaque
);
    localparam int DEPTH  = NUM_PATTERNS * TILE_W * TILE_H;
    localparam int ADDR_W = $clog2(DEPTH);

    // The ROMs hold the built-in ground images; unknown image names
    // leave the layer fully transparent.
    localparam bit GROUND_IMAGES =
        (MEM_FILE == "Ground_tiles.txt") &&
        (PALETTE_FILE == "Ground_palette.txt");

    function automatic logic [BPP-1:0] pix_rom(input logic [ADDR_W-1:0] a);
        int pat;
        int row;
        int col;
        pat = int'(a) / (TILE_W * TILE_H);
        row = (int'(a) / TILE_W) % TILE_H;
        col = int'(a) % TILE_W;
        return GROUND_IMAGES ? BPP'(ground_pixel(pat, row, col)) : '0;
    endfunction

    function automatic logic [23:0] pal_rom(input logic [BPP-1:0] i);
        return GROUND_IMAGES ? ground_color(int'(i)) : 24'h0;
    endfunction

    ch_state_t               r_bank [2][NUM_CHANNELS];
    logic                    r_front;
    logic [9:0]              r_scroll [NUM_CHANNELS];
    logic [9:0]              r_prev_vcount;
    logic [NUM_CHANNELS-1:0] r_s1_hit;
    logic [ADDR_W-1:0]       r_s1_addr [NUM_CHANNELS];
    logic [23:0]             r_rgb;
    logic                    r_opaque;

    cmd_t                    w_cmd;
    logic                    w_swap;
    logic                    w_wr_ok;
    logic                    w_frame_start;
    ch_state_t               w_front [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_hit;
    logic [ADDR_W-1:0]       w_addr [NUM_CHANNELS];
    logic [BPP-1:0]          w_pix [NUM_CHANNELS];
    logic [BPP-1:0]          w_sel_pix;
    logic                    w_any;

    assign w_cmd   = decode_cmd(writedata);
    assign w_swap  = write && (w_cmd.action == ACT_SWAP);
    assign w_wr_ok = write && cmd_is_write(w_cmd, COMPONENT_ID) &&
                     (int'(w_cmd.channel) < NUM_CHANNELS);

    // Apply swap / bank-write commands; swap ignores the component.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_front <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
        end else if (w_swap) begin
            r_front <= w_cmd.bank;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_bank[~w_cmd.bank][c].visible <= 1'b0;
            end
        end else if (w_wr_ok) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_cmd.channel == 5'(c)) begin
                    case (w_cmd.ctype)
                        TYPE_CTRL: begin
                            r_bank[w_cmd.bank][c].visible <= w_cmd.message[12];
                            r_bank[w_cmd.bank][c].flip    <= w_cmd.message[11];
                            if (int'(w_cmd.message[4:0]) < NUM_PATTERNS)
                                r_bank[w_cmd.bank][c].pattern <= w_cmd.message[4:0];
                        end
                        TYPE_X:
                            r_bank[w_cmd.bank][c].x <= w_cmd.message[9:0];
                        TYPE_Y:
                            r_bank[w_cmd.bank][c].y <= w_cmd.message[9:0];
                        TYPE_SPAN:
                            r_bank[w_cmd.bank][c].span <= w_cmd.message[9:0];
                        TYPE_GAPL:
                            r_bank[w_cmd.bank][c].gap_l <= w_cmd.message[9:0];
                        TYPE_GAPR:
                            r_bank[w_cmd.bank][c].gap_r <= w_cmd.message[9:0];
                        TYPE_SPEED:
                            r_bank[w_cmd.bank][c].speed <= w_cmd.message[5:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Select the front bank seen by the address generators.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_front[c] = r_bank[r_front][c];
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        strip_addr_gen #(
            .TILE_W (TILE_W),
            .TILE_H (TILE_H),
            .ADDR_W (ADDR_W)
        ) u_addr (
            .i_state  (w_front[g]),
            .i_hcount (hcount),
            .i_vcount (vcount),
            .i_scroll (r_scroll[g]),
            .o_hit    (w_hit[g]),
            .o_addr   (w_addr[g])
        );
    end

    assign w_frame_start = (hcount == 10'd0) && (vcount == 10'd0) &&
                           (r_prev_vcount != 10'd0);

    // Step every channel's scroll once per frame by its front speed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_vcount <= 10'd0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_scroll[c] <= 10'd0;
            end
        end else begin
            r_prev_vcount <= vcount;
            if (w_frame_start) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    r_scroll[c] <= r_scroll[c] + speed_ext(w_front[c].speed);
                end
            end
        end
    end

    // Stage 1: capture per-channel hit and pixel address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_hit <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_s1_addr[c] <= '0;
            end
        end else begin
            r_s1_hit <= w_hit;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_s1_addr[c] <= w_addr[c];
            end
        end
    end

    // Tile ROM read for every channel.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_pix[c] = pix_rom(r_s1_addr[c]);
        end
    end

    // Lowest-index opaque channel wins; index 0 is transparent.
    always_comb begin
        w_sel_pix = '0;
        w_any     = 1'b0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (r_s1_hit[c] && (w_pix[c] != '0)) begin
                w_any     = 1'b1;
                w_sel_pix = w_pix[c];
            end
        end
    end

    // Stage 2: palette lookup and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb    <= BG_COLOR;
            r_opaque <= 1'b0;
        end else begin
            r_rgb    <= w_any ? pal_rom(w_sel_pix) : BG_COLOR;
            r_opaque <= w_any;
        end
    end

    assign RGB_output = r_rgb;
    assign opaque     = r_opaque;

endmodule

// File: tb/tb_tiled_layer_display.sv
// Directed bench for tiled_layer_display with a pixel scoreboard
// fed by an independent model of banks, scroll and tile images.
module tb_tiled_layer_display;

    typedef struct {
        int          h;
        int          v;
        logic [24:0] e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [9:0]  hcount = 10'd0;
    logic [9:0]  vcount = 10'd0;
    logic [23:0] RGB_output;
    logic        opaque;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    int m_vis[2][4];
    int m_flip[2][4];
    int m_pat[2][4];
    int m_x[2][4];
    int m_y[2][4];
    int m_span[2][4];
    int m_gl[2][4];
    int m_gr[2][4];
    int m_spd[2][4];
    int m_scroll[4];
    int m_front;
    int m_prev_v;

    always #5 clk = ~clk;

    tiled_layer_display dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .writedata  (writedata),
        .hcount     (hcount),
        .vcount     (vcount),
        .RGB_output (RGB_output),
        .opaque     (opaque)
    );

    function automatic logic [23:0] pal(input int i);
        return 24'(i * 32'h405060 + 32'h0A0B0C);
    endfunction

    function automatic logic [31:0] wcmd(input int ch, input int ty,
                                         input int bk, input int msg);
        return {6'b001111, 5'(ch), 4'h1, 3'(ty), 1'(bk), 13'(msg)};
    endfunction

    function automatic logic [31:0] swp(input int bk);
        return {6'd0, 5'd0, 4'hF, 3'd0, 1'(bk), 13'd0};
    endfunction

    function automatic logic [24:0] model_pixel(input int h, input int v);
        int f;
        int col;
        int row;
        int pix;
        f = m_front;
        for (int c = 0; c < 4; c++) begin
            if (m_vis[f][c] != 0 &&
                h >= m_x[f][c] && h < m_x[f][c] + m_span[f][c] &&
                v >= m_y[f][c] && v < m_y[f][c] + 16 &&
                !(m_gl[f][c] <= m_gr[f][c] &&
                  h >= m_gl[f][c] && h <= m_gr[f][c])) begin
                col = (h - m_x[f][c] + m_scroll[c]) & 15;
                if (m_flip[f][c] != 0) col = 15 - col;
                row = v - m_y[f][c];
                pix = (col + col / 4 + row / 4 + 2 * m_pat[f][c]) % 4;
                if (pix != 0) return {1'b1, pal(pix)};
            end
        end
        return {1'b0, 24'h202020};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) begin
                m_vis[b][c] = 0;  m_flip[b][c] = 0; m_pat[b][c] = 0;
                m_x[b][c] = 0;    m_y[b][c] = 0;    m_span[b][c] = 0;
                m_gl[b][c] = 0;   m_gr[b][c] = 0;   m_spd[b][c] = 0;
            end
        end
        for (int c = 0; c < 4; c++) m_scroll[c] = 0;
        m_front = 0;
        m_prev_v = 0;
    endtask

    task automatic apply_cmd(input logic [31:0] w);
        int ch;
        int bk;
        logic [12:0] m;
        ch = int'(w[25:21]);
        bk = int'(w[13]);
        m = w[12:0];
        if (w[20:17] == 4'hF) begin
            m_front = bk;
            for (int c = 0; c < 4; c++) m_vis[1 - bk][c] = 0;
        end else if (w[20:17] == 4'h1 && w[31:26] == 6'b001111 && ch < 4) begin
            case (w[16:14])
                3'b001: begin
                    m_vis[bk][ch] = int'(m[12]);
                    m_flip[bk][ch] = int'(m[11]);
                    if (int'(m[4:0]) < 2) m_pat[bk][ch] = int'(m[4:0]);
                end
                3'b010: m_x[bk][ch] = int'(m[9:0]);
                3'b011: m_y[bk][ch] = int'(m[9:0]);
                3'b100: m_span[bk][ch] = int'(m[9:0]);
                3'b101: m_gl[bk][ch] = int'(m[9:0]);
                3'b110: m_gr[bk][ch] = int'(m[9:0]);
                3'b111: m_spd[bk][ch] = m[5] ? int'(m[5:0]) - 64 : int'(m[5:0]);
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [24:0] got,
                         input logic [24:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got opaque/rgb=%h want %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the expected pixel, compare the
    // pixel that entered the pipeline one cycle earlier.
    task automatic tick(input bit we, input logic [31:0] wd,
                        input int h, input int v);
        exp_t e;
        @(negedge clk);
        write = we;
        writedata = wd;
        hcount = 10'(h);
        vcount = 10'(v);
        e.h = h;
        e.v = v;
        e.e = model_pixel(h, v);
        q.push_back(e);
        if (h == 0 && v == 0 && m_prev_v != 0) begin
            for (int c = 0; c < 4; c++)
                m_scroll[c] = (m_scroll[c] + m_spd[m_front][c] + 1024) % 1024;
        end
        m_prev_v = v;
        if (we) apply_cmd(wd);
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            check($sformatf("pix h=%0d v=%0d", e.h, e.v),
                  {opaque, RGB_output}, e.e);
        end
    endtask

    task automatic cmd(input logic [31:0] w);
        tick(1'b1, w, 700, 600);
    endtask

    task automatic sweep(input int v, input int h0, input int h1, input int st);
        for (int h = h0; h <= h1; h += st) tick(1'b0, 32'd0, h, v);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        write = 1'b0;
        hcount = 10'd0;
        vcount = 10'd0;
        #1;
        check(tag, {opaque, RGB_output}, {1'b0, 24'h202020});
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {opaque, RGB_output}, {1'b0, 24'h202020});
        @(negedge clk);
        reset = 1'b0;

        // idle frame: background everywhere
        sweep(0, 0, 639, 13);
        sweep(368, 0, 639, 17);
        sweep(479, 0, 639, 23);

        // single strip in bank 0
        cmd(wcmd(0, 2, 0, 0));
        cmd(wcmd(0, 3, 0, 368));
        cmd(wcmd(0, 4, 0, 640));
        cmd(wcmd(0, 1, 0, 13'h1000));
        cmd(swp(0));
        sweep(367, 0, 639, 29);
        sweep(368, 0, 47, 1);
        sweep(375, 600, 639, 1);
        sweep(383, 0, 639, 11);
        sweep(384, 0, 639, 29);

        // gap window, then an inverted (disabled) window
        cmd(wcmd(0, 5, 0, 100));
        cmd(wcmd(0, 6, 0, 131));
        sweep(374, 95, 136, 1);
        cmd(wcmd(0, 5, 0, 200));
        cmd(wcmd(0, 6, 0, 150));
        sweep(374, 140, 210, 5);

        // ping-pong: bank 1 shifted by 64, swapped mid-line
        cmd(wcmd(0, 2, 1, 64));
        cmd(wcmd(0, 3, 1, 368));
        cmd(wcmd(0, 4, 1, 640));
        cmd(wcmd(0, 1, 1, 13'h1000));
        for (int h = 30; h < 50; h++) tick(h == 40, swp(1), h, 374);
        sweep(374, 56, 90, 1);
        cmd(swp(0));
        sweep(374, 0, 639, 31);

        // priority and flip: ch0 mirrored over ch1 pattern 1
        cmd(wcmd(0, 2, 1, 0));
        cmd(wcmd(0, 3, 1, 100));
        cmd(wcmd(0, 4, 1, 64));
        cmd(wcmd(0, 1, 1, 13'h1800));
        cmd(wcmd(1, 2, 1, 0));
        cmd(wcmd(1, 3, 1, 100));
        cmd(wcmd(1, 4, 1, 64));
        cmd(wcmd(1, 1, 1, 13'h1001));
        cmd(swp(1));
        sweep(101, 0, 70, 1);

        // filtered writes leave state unchanged
        cmd({6'b000001, 5'd0, 4'h1, 3'b010, 1'b1, 13'd300});
        cmd(wcmd(4, 2, 1, 300));
        tick(1'b0, wcmd(0, 2, 1, 300), 700, 600);
        cmd(wcmd(0, 0, 1, 300));
        cmd(wcmd(0, 1, 1, 13'h1805));
        sweep(105, 0, 70, 3);

        // scroll: speed -3 for six frame starts wraps to 1006
        cmd(wcmd(0, 1, 1, 13'h1000));
        cmd(wcmd(0, 5, 1, 1));
        cmd(wcmd(1, 5, 1, 1));
        cmd(wcmd(0, 7, 1, 13'h3D));
        repeat (6) begin
            tick(1'b0, 32'd0, 5, 1);
            tick(1'b0, 32'd0, 0, 0);
        end
        sweep(101, 0, 20, 1);
        sweep(113, 0, 20, 4);

        // reset mid-line clears output at once and all state
        do_reset("async_reset");
        sweep(101, 0, 30, 3);
        sweep(374, 0, 90, 9);
        tick(1'b0, 32'd0, 700, 600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
